// File: rtl/lsu.sv
// Memory-stage load/store unit: one req/ack bus transaction per load or store,
// with byte-lane steering on stores and lane extraction plus extension on loads.
package pipeline;
  parameter int XLEN = 64;

  typedef struct packed {
    logic            mm_re;
    logic            mm_we;
    logic [XLEN-1:0] mm_addr;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
    logic [4:0]      rd_addr;
  } memory_signals;
endpackage

module lsu #(
  parameter int XLEN = pipeline::XLEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pipeline::memory_signals signals_in,
  input  logic                    hold,
  output logic                    stall,
  output logic                    wb_we,
  output logic [4:0]              wb_rd_addr,
  output logic [XLEN-1:0]         wb_data,
  output logic                    exc_misaligned,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [XLEN-1:0]         dbus_addr,
  output logic [7:0]              dbus_wstrb,
  output logic [XLEN-1:0]         dbus_wdata,
  input  logic [XLEN-1:0]         dbus_rdata,
  input  logic                    dbus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [7:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] ld_q;
  logic [2:0]      off_q;
  logic [2:0]      f3_q;
  logic            load_q;
  logic [4:0]      rd_q;

  logic       is_mem;
  logic       misaligned;
  logic       issue;
  logic [2:0] off;
  logic [1:0] size;
  logic [7:0] strb_mask;

  assign is_mem = signals_in.mm_re | signals_in.mm_we;
  assign off    = signals_in.mm_addr[2:0];
  assign size   = signals_in.funct3[1:0];

  always_comb begin
    misaligned = 1'b0;
    strb_mask  = 8'h01;
    case (size)
      2'b00: begin misaligned = 1'b0;     strb_mask = 8'h01; end
      2'b01: begin misaligned = off[0];   strb_mask = 8'h03; end
      2'b10: begin misaligned = |off[1:0]; strb_mask = 8'h0F; end
      2'b11: begin misaligned = |off;     strb_mask = 8'hFF; end
      default: ;
    endcase
  end

  // Lane data is already shifted down to bit 0; truncate to size and extend.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    logic [XLEN-1:0] r;
    r = raw;
    case (f3[1:0])
      2'b00: r = f3[2] ? {{(XLEN-8){1'b0}}, raw[7:0]}   : {{(XLEN-8){raw[7]}}, raw[7:0]};
      2'b01: r = f3[2] ? {{(XLEN-16){1'b0}}, raw[15:0]} : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'b10: r = f3[2] ? {{(XLEN-32){1'b0}}, raw[31:0]} : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    issue          = 1'b0;
    exc_misaligned = 1'b0;
    wb_we          = 1'b0;
    wb_rd_addr     = signals_in.rd_addr;
    wb_data        = signals_in.data;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wb_we = (signals_in.rd_addr != 5'd0);
        end else if (misaligned) begin
          exc_misaligned = 1'b1;
        end else begin
          stall   = 1'b1;
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall      = 1'b1;
        wb_rd_addr = rd_q;
        wb_data    = '0;
        if (dbus_ack) state_d = DONE;
      end
      DONE: begin
        wb_rd_addr = rd_q;
        wb_data    = load_q ? ld_q : '0;
        wb_we      = load_q & (rd_q != 5'd0);
        if (!hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        req_q   <= 1'b1;
        // Both enables high is treated as a store.
        we_q    <= signals_in.mm_we;
        load_q  <= signals_in.mm_re & ~signals_in.mm_we;
        addr_q  <= {signals_in.mm_addr[XLEN-1:3], 3'b000};
        wstrb_q <= strb_mask << off;
        wdata_q <= signals_in.data << {off, 3'b000};
        off_q   <= off;
        f3_q    <= signals_in.funct3;
        rd_q    <= signals_in.rd_addr;
      end
      if (state_q == REQ && dbus_ack) begin
        req_q <= 1'b0;
        ld_q  <= extend(dbus_rdata >> {off_q, 3'b000}, f3_q);
      end
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wstrb = wstrb_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads with wait states, stores,
// misalignment, hold freezing, back-to-back issue and reset mid-transaction.
module tb_lsu;
  logic                    clk = 1'b0;
  logic                    reset;
  pipeline::memory_signals sig;
  logic                    hold;
  logic                    stall, wb_we, exc_misaligned;
  logic [4:0]              wb_rd_addr;
  logic [63:0]             wb_data;
  logic                    dbus_req, dbus_we, dbus_ack;
  logic [63:0]             dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]              dbus_wstrb;

  int errors = 0;
  int checks = 0;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .signals_in(sig), .hold(hold),
    .stall(stall), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic re, input logic we, input logic [63:0] addr,
                       input logic [63:0] data, input logic [2:0] f3, input logic [4:0] rd);
    sig.mm_re   = re;
    sig.mm_we   = we;
    sig.mm_addr = addr;
    sig.data    = data;
    sig.funct3  = f3;
    sig.rd_addr = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({stall, wb_we, exc_misaligned, dbus_req, dbus_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {stall, wb_we, exc_misaligned, dbus_req, dbus_we});
    end
    checks++;
    if ({dbus_addr, dbus_wstrb, dbus_wdata, wb_data, wb_rd_addr} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h wstrb=%h wdata=%h wb_data=%h rd=%0d expected all zero",
                         dbus_addr, dbus_wstrb, dbus_wdata, wb_data, wb_rd_addr);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 64'h1234, 3'd0, 5'd5); #1;
    checks++;
    if ({stall, wb_we} !== 2'b01 || wb_data !== 64'h1234 || wb_rd_addr !== 5'd5) begin
      errors++; $display("FAIL pass_rd5: stall=%b we=%b data=%h rd=%0d expected 0 1 1234 5", stall, wb_we, wb_data, wb_rd_addr);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 64'h1234, 3'd0, 5'd0); #1;
    checks++;
    if (wb_we !== 1'b0 || stall !== 1'b0 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL pass_rd0: we=%b stall=%b req=%b expected 0 0 0", wb_we, stall, dbus_req);
    end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [63:0] exp, input string name);
    int reqcnt = 0;
    bit done = 0;
    @(negedge clk);
    dbus_rdata = 64'h8000_0000_8000_0000;
    drive(1'b1, 1'b0, 64'h1003, 64'h0, f3, 5'd7); #1;
    checks++;
    if (stall !== 1'b1 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL %s_issue: stall=%b req=%b expected 1 0", name, stall, dbus_req);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      if (dbus_req) begin
        reqcnt++;
        if (reqcnt == 1) begin
          checks++;
          if (dbus_addr !== 64'h1000 || dbus_we !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL %s_bus: addr=%h we=%b stall=%b expected 1000 0 1", name, dbus_addr, dbus_we, stall);
          end
        end
        if (reqcnt == 4) dbus_ack = 1'b1;
      end else if (reqcnt > 0) begin
        done = 1;
      end
    end
    dbus_ack = 1'b0;
    checks++;
    if (!done || reqcnt != 4) begin
      errors++; $display("FAIL %s_reqcycles: got %0d (done=%0b) expected 4", name, reqcnt, done);
    end
    checks++;
    if (stall !== 1'b0 || wb_we !== 1'b1 || wb_data !== exp || wb_rd_addr !== 5'd7) begin
      errors++; $display("FAIL %s_result: stall=%b we=%b data=%h rd=%0d expected 0 1 %h 7", name, stall, wb_we, wb_data, wb_rd_addr, exp);
    end
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
  endtask

  task automatic test_store();
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h2006, 64'hABCD, 3'b001, 5'd0);
    @(negedge clk); #1;
    checks++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== 64'h2000) begin
      errors++; $display("FAIL sh_ctrl: req=%b we=%b addr=%h expected 1 1 2000", dbus_req, dbus_we, dbus_addr);
    end
    checks++;
    if (dbus_wstrb !== 8'hC0 || dbus_wdata !== 64'hABCD_0000_0000_0000) begin
      errors++; $display("FAIL sh_lane: wstrb=%h wdata=%h expected c0 abcd000000000000", dbus_wstrb, dbus_wdata);
    end
    dbus_ack = 1'b1;
    @(negedge clk); #1;
    dbus_ack = 1'b0;
    checks++;
    if (stall !== 1'b0 || wb_we !== 1'b0 || wb_data !== 64'h0 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL sh_done: stall=%b we=%b data=%h req=%b expected 0 0 0 0", stall, wb_we, wb_data, dbus_req);
    end
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
  endtask

  task automatic test_misaligned();
    bit saw_req = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h3002, 64'h0, 3'b010, 5'd3); #1;
    checks++;
    if (exc_misaligned !== 1'b1 || stall !== 1'b0 || wb_we !== 1'b0) begin
      errors++; $display("FAIL lw_misaligned: exc=%b stall=%b we=%b expected 1 0 0", exc_misaligned, stall, wb_we);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (dbus_req) saw_req = 1;
    end
    checks++;
    if (saw_req) begin
      errors++; $display("FAIL lw_nobus: dbus_req got 1 expected 0");
    end
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0); #1;
    checks++;
    if (exc_misaligned !== 1'b0) begin
      errors++; $display("FAIL exc_clear: got %b expected 0", exc_misaligned);
    end
  endtask

  task automatic test_hold_back_to_back();
    @(negedge clk);
    dbus_rdata = 64'h0123_4567_89AB_CDEF;
    drive(1'b1, 1'b0, 64'h4008, 64'h0, 3'b011, 5'd9);
    @(negedge clk); #1;
    dbus_ack = 1'b1;
    @(negedge clk); #1;
    dbus_ack = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hold = 1'b0;
      checks++;
      if (wb_data !== 64'h0123_4567_89AB_CDEF || wb_we !== 1'b1 || stall !== 1'b0 || dbus_req !== 1'b0) begin
        errors++; $display("FAIL ld_hold%0d: data=%h we=%b stall=%b req=%b expected 0123456789abcdef 1 0 0",
                           i, wb_data, wb_we, stall, dbus_req);
      end
      if (i < 2) begin @(negedge clk); #1; end
    end
    dbus_rdata = 64'hFEDC_BA98_7654_3210;
    drive(1'b1, 1'b0, 64'h5000, 64'h0, 3'b011, 5'd10);
    @(negedge clk); #1;
    checks++;
    if (dbus_req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: req=%b stall=%b expected 0 1", dbus_req, stall);
    end
    @(negedge clk); #1;
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 64'h5000) begin
      errors++; $display("FAIL b2b_req: req=%b addr=%h expected 1 5000", dbus_req, dbus_addr);
    end
    dbus_ack = 1'b1;
    @(negedge clk); #1;
    dbus_ack = 1'b0;
    checks++;
    if (wb_data !== 64'hFEDC_BA98_7654_3210 || wb_rd_addr !== 5'd10 || wb_we !== 1'b1) begin
      errors++; $display("FAIL b2b_result: data=%h rd=%0d we=%b expected fedcba9876543210 10 1", wb_data, wb_rd_addr, wb_we);
    end
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    dbus_rdata = 64'h1111_2222_3333_4444;
    drive(1'b1, 1'b0, 64'h6000, 64'h0, 3'b011, 5'd4);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (dbus_req !== 1'b1) begin
      errors++; $display("FAIL rst_req_pre: req=%b expected 1", dbus_req);
    end
    reset = 1'b1; dbus_ack = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
    @(negedge clk); #1;
    reset = 1'b0; dbus_ack = 1'b0;
    checks++;
    if ({stall, wb_we, exc_misaligned, dbus_req, dbus_we} !== 5'b0 ||
        {dbus_addr, dbus_wstrb, dbus_wdata, wb_data} !== '0) begin
      errors++; $display("FAIL rst_in_req: stall=%b we=%b req=%b addr=%h data=%h expected all zero",
                         stall, wb_we, dbus_req, dbus_addr, wb_data);
    end
    @(negedge clk); #1;
    checks++;
    if (dbus_req !== 1'b0 || wb_we !== 1'b0 || stall !== 1'b0 || wb_data !== 64'h0) begin
      errors++; $display("FAIL rst_idle: req=%b we=%b stall=%b data=%h expected 0 0 0 0", dbus_req, wb_we, stall, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load(3'b000, 64'hFFFF_FFFF_FFFF_FF80, "lb");
    test_load(3'b100, 64'h0000_0000_0000_0080, "lbu");
    test_store();
    test_misaligned();
    test_hold_back_to_back();
    test_reset_in_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Memory-stage load/store unit. Consumes the `memory_signals` bundle produced by the execute stage (access type, effective address, store data, funct3, destination register). It runs one data-bus transaction per load or store over a req/ack handshake, stalling the pipeline while the transaction is outstanding. It presents write-back data with byte-lane extraction and sign/zero extension. Non-memory operations pass through in the same cycle.

## Interface
Parameters:
- `XLEN`, default `pipeline::XLEN` (64): data and address width. The bus carries one doubleword with 8 byte strobes.

Ports:
- `clk`  in  1  clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `signals_in`  in  `memory_signals`  fields used: `mm_re`, `mm_we`, `mm_addr`, `data` (store data, or ALU/link result), `funct3`, `rd_addr`.
- `hold`  in  1  downstream stall; freezes the completed result.
- `stall`  out  1  high while this stage cannot retire the current instruction.
- `wb_we`  out  1  register write enable.
- `wb_rd_addr`  out  5  destination register.
- `wb_data`  out  XLEN  write-back value.
- `exc_misaligned`  out  1  misaligned access detected; one-cycle pulse unless held.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  1 = write.
- `dbus_addr`  out  XLEN  doubleword-aligned address (`mm_addr` with bits [2:0] cleared).
- `dbus_wstrb`  out  8  byte strobes.
- `dbus_wdata`  out  XLEN  store data shifted to its byte lane.
- `dbus_rdata`  in  XLEN  read data; valid when `dbus_ack` is high.
- `dbus_ack`  in  1  transaction complete; sampled on `clk` edges while `dbus_req` is high.

## Operation
- Access size is set by `funct3[1:0]`: 00 byte, 01 half, 10 word, 11 double. For loads, `funct3[2]` = 1 selects zero-extension; otherwise the value is sign-extended.
- Alignment: half needs `addr[0]` = 0; word needs `addr[1:0]` = 0; double needs `addr[2:0]` = 0.
- Lane offset is `addr[2:0]`:
  - Store: `wstrb` = (1, 3, 15 or 255 by size) << offset; `wdata` = store data << (8*offset).
  - Load: `rdata` >> (8*offset), truncated to size, then extended.
- FSM states:
  - **IDLE**
    - Non-memory op (`mm_re` = `mm_we` = 0): `stall` = 0; `wb_data` = `data`; `wb_we` = (`rd_addr` != 0). Stay in IDLE.
    - Aligned access: `stall` = 1; register bus fields; go to REQ.
    - Misaligned access: `stall` = 0; `exc_misaligned` = 1; `wb_we` = 0; no bus activity; stay in IDLE.
  - **REQ**
    - `dbus_req` = 1; bus fields are registered and held stable; `stall` = 1.
    - On an edge with `dbus_ack` = 1: capture the extended load result; go to DONE.
  - **DONE**
    - `stall` = 0; `wb_data` = captured load data, or 0 for a store.
    - `wb_we` = `mm_re` & (`rd_addr` != 0).
    - If `hold` = 1, stay in DONE with outputs frozen; otherwise return to IDLE.
- `mm_re` and `mm_we` both high is illegal. It is treated as a store.
- Upstream keeps `signals_in` stable while `stall` = 1.
- Only one outstanding transaction is allowed.

## Timing
- Reset values: `stall` 0, `wb_we` 0, `wb_rd_addr` 0, `wb_data` 0, `exc_misaligned` 0, `dbus_req` 0, `dbus_we` 0, `dbus_addr` 0, `dbus_wstrb` 0, `dbus_wdata` 0. FSM resets to IDLE.
- Reset during REQ:
  - `dbus_req` is low in the cycle after the reset edge.
  - An ack arriving on the reset edge is discarded.
  - The bus must tolerate an abandoned request.
- Pass-through (non-memory or misaligned): combinational, 0 added cycles.
- Memory access with ack in the first REQ cycle:
  - cycle 0 IDLE (stall = 1); cycle 1 REQ (stall = 1); cycle 2 DONE (stall = 0, result valid).
  - Each extra wait cycle adds one REQ cycle.
- `dbus_req` is registered; no combinational path from `dbus_ack` to `dbus_req`.
- `stall` depends combinationally only on `signals_in` and the FSM state.
- `dbus_ack` is ignored when `dbus_req` = 0.
- Back-to-back accesses: the DONE→IDLE edge accepts the next instruction. The next request asserts 2 cycles after the previous DONE cycle.

## Test plan
- Pass-through: ALU op, `rd_addr` = 5, `data` = 0x1234 → same cycle `stall` = 0, `wb_we` = 1, `wb_data` = 0x1234. Repeat with `rd_addr` = 0 → `wb_we` = 0.
- LB at 0x1003, `dbus_rdata` = 0x8000_0000_8000_0000, ack after 3 wait cycles → `dbus_addr` = 0x1000, `dbus_req` high for 4 cycles, then `wb_data` = 0xFFFF_FFFF_FFFF_FF80. The same access as LBU gives 0x80.
- SH at 0x2006, data 0xABCD → `dbus_wstrb` = 0xC0, `dbus_wdata` = 0xABCD << 48, `dbus_we` = 1, DONE with `wb_we` = 0.
- LW at 0x3002 → `exc_misaligned` = 1 the same cycle, `dbus_req` never asserts, `stall` = 0.
- LD completes with `hold` = 1 for 2 cycles → `wb_data` frozen for 3 cycles, no new request. After `hold` falls, the next LD issues `dbus_req` 2 cycles later.
- `reset` asserted in the second REQ cycle with `dbus_ack` = 1 on the same edge → all outputs take reset values next cycle, FSM in IDLE, no write-back.
